// File: rtl/bram_stream_pkg.sv
// ----------------------------------------------------------------------------
// Package: bram_stream_pkg
// Purpose: Shared types and field constants for the BRAM stream instruction
//          path. The 64-bit instruction word carries
//          {.., wr[26], addr[25:13], length[12:0]}.
// Contents:
//   state_t    arbiter FSM states (IDLE, ISSUE, BUSY)
//   INSTR_W    instruction word width
//   LEN_*      length field position/width
//   ADDR_*     address field position/width
//   WR_BIT     write/read select bit
//   makeInstr  packs the wr/addr/length fields into an instruction word
// ----------------------------------------------------------------------------
package bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam int INSTR_W  = 64;
  localparam int LEN_LSB  = 0;
  localparam int LEN_W    = 13;
  localparam int ADDR_LSB = 13;
  localparam int ADDR_W   = 13;
  localparam int WR_BIT   = 26;

  // Builds an instruction word with every bit outside the known fields cleared.
  function automatic logic [INSTR_W-1:0] makeInstr(input logic wr,
                                                   input logic [ADDR_W-1:0] addr,
                                                   input logic [LEN_W-1:0] len);
    logic [INSTR_W-1:0] word;
    word = '0;
    word[WR_BIT] = wr;
    word[ADDR_LSB +: ADDR_W] = addr;
    word[LEN_LSB +: LEN_W] = len;
    return word;
  endfunction

endpackage

// File: rtl/bram_instr_arbiter_if.sv
// ----------------------------------------------------------------------------
// Interface: bram_instr_arbiter_if
// Purpose: Bundles every handshake/bus signal around bram_instr_arbiter.
// Signals:
//   s_req_tdata/tvalid/tready  requester instruction streams (slice i = [64*i+:64])
//   req_done                   one-cycle completion pulse per requester
//   m_instruct_tdata/tvalid/tready  instruction port toward the BRAM slave
//   mon_in_*                   snoop of the BRAM write-data stream
//   mon_out_*                  snoop of the BRAM read-data stream
//   grant_id, busy, err_timeout  status
// Modports:
//   slave   the arbiter's view
//   master  the environment's view (requesters, BRAM slave, monitors)
// ----------------------------------------------------------------------------
interface bram_instr_arbiter_if #(
  parameter int NREQ = 4
);
  import bram_stream_pkg::*;

  localparam int IDW = $clog2(NREQ);

  logic [NREQ*INSTR_W-1:0] s_req_tdata;
  logic [NREQ-1:0]         s_req_tvalid;
  logic [NREQ-1:0]         s_req_tready;
  logic [NREQ-1:0]         req_done;
  logic [INSTR_W-1:0]      m_instruct_tdata;
  logic                    m_instruct_tvalid;
  logic                    m_instruct_tready;
  logic                    mon_in_tvalid;
  logic                    mon_in_tready;
  logic                    mon_in_tlast;
  logic                    mon_out_tvalid;
  logic                    mon_out_tready;
  logic                    mon_out_tlast;
  logic [IDW-1:0]          grant_id;
  logic                    busy;
  logic                    err_timeout;

  modport slave (
    input  s_req_tdata, s_req_tvalid, m_instruct_tready,
           mon_in_tvalid, mon_in_tready, mon_in_tlast,
           mon_out_tvalid, mon_out_tready, mon_out_tlast,
    output s_req_tready, req_done, m_instruct_tdata, m_instruct_tvalid,
           grant_id, busy, err_timeout
  );

  modport master (
    output s_req_tdata, s_req_tvalid, m_instruct_tready,
           mon_in_tvalid, mon_in_tready, mon_in_tlast,
           mon_out_tvalid, mon_out_tready, mon_out_tlast,
    input  s_req_tready, req_done, m_instruct_tdata, m_instruct_tvalid,
           grant_id, busy, err_timeout
  );

endinterface

// File: rtl/bram_instr_arbiter_rr_select.sv
// ----------------------------------------------------------------------------
// Module: rr_select
// Purpose: Combinational round-robin pick. Finds the first set bit of
//          i_valid starting at i_ptr and wrapping cyclically.
// Ports:
//   i_valid  NREQ-bit request vector
//   i_ptr    starting index of the search
//   o_found  any request present
//   o_idx    index of the winning request (0 when none)
// ----------------------------------------------------------------------------
module rr_select #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDW-1:0]  i_ptr,
  output logic            o_found,
  output logic [IDW-1:0]  o_idx
);

  // Walk the offsets from farthest to nearest so the nearest hit is the
  // last one written and therefore wins. The wrap is a subtraction rather
  // than a power-of-two mask so any NREQ works.
  always_comb begin
    int w_j;
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NREQ) begin
        w_j = w_j - NREQ;
      end
      if (i_valid[w_j]) begin
        o_found = 1'b1;
        o_idx   = IDW'(w_j);
      end
    end
  end

endmodule

// File: rtl/bram_instr_arbiter.sv
// ----------------------------------------------------------------------------
// Module: bram_instr_arbiter
// Purpose: Round-robin arbiter sharing one BRAM stream instruction port among
//          NREQ requesters. The winner's instruction is latched and forwarded,
//          and the grant is held until the matching data transfer ends
//          (tlast handshake on the write stream for writes, read stream for
//          reads, both only snooped here).
// Ports:
//   clk    clock
//   rst_n  synchronous reset, active low
//   bus    bram_instr_arbiter_if.slave (requesters, instruction port,
//          stream snoops, grant_id/busy/err_timeout status)
// Parameters:
//   NREQ     number of requesters (2..8)
//   TIMEOUT  BUSY cycles allowed before abort
// Configuration:
//   BRAM_ARB_TIMEOUT_EN  when defined, BUSY aborts after TIMEOUT cycles and
//                        raises a sticky err_timeout; otherwise BUSY waits
//                        indefinitely and err_timeout is 0.
// ----------------------------------------------------------------------------
module bram_instr_arbiter
  import bram_stream_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  bram_instr_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  state_t             r_state;
  state_t             w_nextState;
  logic [IDW-1:0]     r_rrPtr;
  logic [IDW-1:0]     r_grantId;
  logic [IDW-1:0]     w_nextPtr;
  logic [IDW-1:0]     w_selIdx;
  logic               w_selFound;
  logic [INSTR_W-1:0] r_instr;
  logic               r_wr;
  logic [NREQ-1:0]    r_reqDone;
  logic [NREQ-1:0]    w_reqReady;
  logic               w_accept;
  logic               w_issueHs;
  logic               w_lenZero;
  logic               w_complete;
  logic               w_timeout;

  rr_select #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) uRrSelect (
    .i_valid (bus.s_req_tvalid),
    .i_ptr   (r_rrPtr),
    .o_found (w_selFound),
    .o_idx   (w_selIdx)
  );

  // Acceptance is blocked while reset is asserted so no requester sees a
  // stray tready during the reset cycle.
  assign w_accept  = rst_n && (r_state == IDLE) && w_selFound;
  assign w_issueHs = (r_state == ISSUE) && bus.m_instruct_tready;
  assign w_lenZero = (r_instr[LEN_LSB +: LEN_W] == '0);
  assign w_complete = (r_state == BUSY) &&
                      (r_wr ? (bus.mon_in_tvalid  && bus.mon_in_tready  && bus.mon_in_tlast)
                            : (bus.mon_out_tvalid && bus.mon_out_tready && bus.mon_out_tlast));
  assign w_nextPtr = (r_grantId == IDW'(NREQ - 1)) ? '0 : r_grantId + 1'b1;

`ifdef BRAM_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0] r_busyCnt;
  logic            r_err;

  // Counts BUSY cycles from zero on each entry; the cycle holding TIMEOUT-1
  // is the TIMEOUT-th BUSY cycle, at which point the transfer is abandoned.
  // A completion in that same cycle still counts as a normal finish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busyCnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state != BUSY || w_complete) begin
        r_busyCnt <= '0;
      end else begin
        r_busyCnt <= r_busyCnt + 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_timeout = (r_state == BUSY) && !w_complete &&
                     (r_busyCnt == CNTW'(TIMEOUT - 1));
  assign bus.err_timeout = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic plus the one-hot accept toward the chosen requester.
  // A zero-length instruction has no data phase, so it finishes straight
  // from ISSUE.
  always_comb begin
    w_nextState = r_state;
    w_reqReady  = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_reqReady[w_selIdx] = 1'b1;
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        if (w_issueHs) begin
          w_nextState = w_lenZero ? IDLE : BUSY;
        end
      end
      BUSY: begin
        if (w_complete || w_timeout) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Grant/instruction latches, completion pulse and round-robin pointer.
  // The pointer moves past the owner whenever its grant ends (normal
  // completion, zero-length finish or abort) so nobody is granted twice in
  // a row while others wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grantId <= '0;
      r_rrPtr   <= '0;
      r_instr   <= '0;
      r_wr      <= 1'b0;
      r_reqDone <= '0;
    end else begin
      r_reqDone <= '0;
      if (w_accept) begin
        r_grantId <= w_selIdx;
        r_instr   <= bus.s_req_tdata[int'(w_selIdx)*INSTR_W +: INSTR_W];
      end
      if (w_issueHs) begin
        r_wr <= r_instr[WR_BIT];
        if (w_lenZero) begin
          r_reqDone[r_grantId] <= 1'b1;
          r_rrPtr <= w_nextPtr;
        end
      end
      if (w_complete) begin
        r_reqDone[r_grantId] <= 1'b1;
        r_rrPtr <= w_nextPtr;
      end
      if (w_timeout) begin
        r_rrPtr <= w_nextPtr;
      end
    end
  end

  assign bus.s_req_tready      = w_reqReady;
  assign bus.req_done          = r_reqDone;
  assign bus.m_instruct_tdata  = r_instr;
  assign bus.m_instruct_tvalid = (r_state == ISSUE);
  assign bus.grant_id          = r_grantId;
  assign bus.busy              = (r_state != IDLE);

endmodule
